diag_hex_uart: RTL and testbench

DIAG_HEX_UART -- requirements
Module: diag_hex_uart

---
 rtl/diag_hex_uart.sv | 128 ++++++++++++
 tb/tb_diag_hex_uart.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/diag_hex_uart.sv
// diag_hex_uart: periodically snapshots four 12-bit ADC values and sends them
// as one ASCII line "HHH HHH HHH HHH\r\n" over an 8N1 UART transmitter.
module diag_hex_uart #(
  parameter int BAUD_DIV   = 417,
  parameter int PERIOD_CYC = 4800000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [11:0] a0,
  input  logic [11:0] a1,
  input  logic [11:0] a2,
  input  logic [11:0] a3,
  output logic        tx,
  output logic        busy,
  output logic        ovr
);
  localparam int TW = $clog2(PERIOD_CYC + 1);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CYC - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  localparam logic [4:0]    C_LAST = 5'd16;   // LF is the 17th character

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [4:0]    char_idx;
  logic [11:0]   s0, s1, s2, s3;
  logic          trig, accept, bit_end;
  logic [11:0]   field;
  logic [3:0]    nib;
  logic [7:0]    char_byte;

  assign trig    = (timer == T_LAST);
  assign accept  = trig && en && (state == IDLE);
  assign bit_end = (baud_cnt == B_LAST);

  // Free-running frame timer, independent of en and transmitter activity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     timer <= '0;
    else if (trig)    timer <= '0;
    else              timer <= timer + 1'b1;
  end

  // Sticky overrun: an enabled trigger arrived while a frame was in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          ovr <= 1'b0;
    else if (trig && en && state != IDLE)  ovr <= 1'b1;
  end

  // Snapshot inputs on the accepted trigger so the frame is self-consistent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0 <= '0; s1 <= '0; s2 <= '0; s3 <= '0;
    end else if (accept) begin
      s0 <= a0; s1 <= a1; s2 <= a2; s3 <= a3;
    end
  end

  // Baud, bit and character counters; all restart with a new frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_idx <= '0;
    end else if (accept) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_idx <= '0;
    end else if (state != IDLE) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end && state == DATA) bit_cnt <= bit_cnt + 1'b1;  // 7 wraps to 0
      if (bit_end && state == STOP && char_idx != C_LAST) char_idx <= char_idx + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = (char_idx == C_LAST) ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  // Character byte from snapshot: groups of four are (3 hex digits, separator)
  always_comb begin
    case (char_idx[3:2])
      2'd0:    field = s0;
      2'd1:    field = s1;
      2'd2:    field = s2;
      default: field = s3;
    endcase
    case (char_idx[1:0])
      2'd0:    nib = field[11:8];
      2'd1:    nib = field[7:4];
      2'd2:    nib = field[3:0];
      default: nib = 4'd0;
    endcase
    if (char_idx == C_LAST)          char_byte = 8'h0A;
    else if (char_idx == 5'd15)      char_byte = 8'h0D;
    else if (char_idx[1:0] == 2'd3)  char_byte = 8'h20;
    else if (nib < 4'd10)            char_byte = 8'h30 + {4'd0, nib};
    else                             char_byte = 8'h37 + {4'd0, nib};
  end

  // FSM outputs; tx is decoded from state so reset forces it high at once
  always_comb begin
    busy = (state != IDLE);
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = char_byte[bit_cnt];
      default: tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_diag_hex_uart.sv
// Scoreboarded bench for diag_hex_uart: a cycle-count reference model queues
// expected frames, and a UART decoder on the falling edge checks them.
module tb_diag_hex_uart;
  localparam int B  = 4;
  localparam int P  = 500;
  localparam int FL = 170 * B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
  logic        tx, busy, ovr;

  diag_hex_uart #(.BAUD_DIV(B), .PERIOD_CYC(P)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .tx(tx), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         n  = 0;       // rising edges since reset release
  int         fs = 0;       // edge on which the current frame started (0 = none)
  bit         ovr_m = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  // decoder state
  bit         mon_on = 1'b0;
  int         samp = 0, bitn = 0, cif = 0;
  logic       bv = 1'b1;
  logic [7:0] rx = '0;
  bit         eb;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", nm, act, exp, n);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] v);
    logic [7:0] r;
    r = {4'd0, v};
    return (v < 4'd10) ? 8'h30 + r : 8'h41 + r - 8'd10;
  endfunction

  task automatic push_frame(input logic [11:0] v0, v1, v2, v3);
    logic [11:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back(hexc(v[f][11:8]));
      exp_q.push_back(hexc(v[f][7:4]));
      exp_q.push_back(hexc(v[f][3:0]));
      if (f < 3) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Reference model: a trigger lands on every P-th edge after release
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      n = 0; fs = 0; ovr_m = 1'b0;
      exp_q.delete(); start_q.delete();
    end else begin
      n++;
      if (n % P == 0 && en) begin
        if (fs != 0 && n > fs && n <= fs + FL) ovr_m = 1'b1;
        else begin
          fs = n;
          start_q.push_back(n);
          push_frame(a0, a1, a2, a3);
        end
      end
    end
  end

  // Monitor: per-cycle flag checks plus an 8N1 decoder that pops the scoreboard
  initial forever begin
    @(negedge clk);
    eb = reset_n && fs != 0 && n >= fs && n < fs + FL;
    chk("busy", busy, eb);
    chk("ovr", ovr, reset_n && ovr_m);
    if (!eb) chk("tx_idle", tx, 1);
    if (!reset_n) begin
      mon_on = 1'b0; cif = 0;
    end else if (!mon_on) begin
      if (cif != 0) chk("char_gap", tx, 0);
      if (tx == 1'b0) begin
        mon_on = 1'b1; samp = 1; bitn = 0; bv = 1'b0;
        if (cif == 0) begin
          chk("start_pending", start_q.size() > 0, 1);
          if (start_q.size() > 0) chk("start_cycle", n, start_q.pop_front());
        end
      end
    end else begin
      if (samp == B) begin
        bitn++; samp = 0; bv = tx;
        if (bitn >= 1 && bitn <= 8) rx[bitn-1] = tx;
      end else begin
        chk("bit_len", tx, bv);
      end
      samp++;
      if (bitn == 9 && samp == B) begin
        chk("stop_bit", bv, 1);
        chk("char_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("char", rx, exp_q.pop_front());
        mon_on = 1'b0;
        cif = (cif + 1) % 17;
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #3;
  endtask

  // Stimulus
  initial begin
    cyc(3);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_ovr", ovr, 0);
    reset_n = 1'b1;
    a0 = 12'h123; a1 = 12'hABC; a2 = 12'h000; a3 = 12'hFFF;
    cyc(600);                 // edge-500 trigger with en=0 is ignored
    en = 1'b1;
    cyc(450);                 // frame from edge 1000 in flight
    a0 = 12'h456;             // must not disturb the running frame
    cyc(500);                 // edge-1500 trigger dropped -> ovr
    cyc(500);                 // edge-2000 frame reports 456
    en = 1'b0;                // mid-frame disable, frame still completes
    cyc(1000);
    en = 1'b1;
    cyc(500);                 // frame from edge 3500
    cyc(151);                 // inside start bit of character 5
    chk("pre_rst_tx", tx, 0);
    reset_n = 1'b0;
    #1;
    chk("async_tx", tx, 1); chk("async_busy", busy, 0); chk("async_ovr", ovr, 0);
    cyc(2);
    reset_n = 1'b1;
    a0 = 12'h9A0; a1 = 12'($urandom); a2 = 12'($urandom); a3 = 12'($urandom);
    cyc(P + 10);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) begin
        case ($urandom_range(3))
          0: a0 = 12'($urandom);
          1: a1 = 12'($urandom);
          2: a2 = 12'($urandom);
          default: a3 = 12'($urandom);
        endcase
      end
      if ($urandom_range(399) == 0) en = ~en;
      cyc(1);
    end
    en = 1'b0;
    cyc(FL + 20);
    chk("drained_chars", exp_q.size(), 0);
    chk("drained_starts", start_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
